// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a framed program image from a byte stream (UART),
//               writes the payload into program memory and holds the core in
//               reset until a load completes with a valid checksum.
//               Frame: A5, LEN_LO, LEN_HI, LEN payload bytes, CHK (sum mod 256).
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int unsigned MEM_BYTES      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        write_enable,
    output logic [7:0]  write_data,
    output logic [31:0] write_address,
    output logic        cpu_hold,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [7:0] c_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_len;
    logic [16:0] r_index;
    logic [7:0]  r_checksum;
    logic [31:0] r_timer;

    logic [15:0] w_len_rx;
    logic        w_len_too_big;
    logic        w_last_byte;
    logic        w_timeout;

    // Full length as it becomes known while the high byte is being received
    assign w_len_rx      = {rx_data, r_len[7:0]};
    assign w_len_too_big = ({16'd0, w_len_rx} > MEM_BYTES);
    // The byte being accepted is payload byte LEN-1
    assign w_last_byte   = ((r_index + 17'd1) == {1'b0, r_len});
    // Inter-byte gap has run out; an arriving byte always wins over the timeout
    assign w_timeout     = (r_state != S_IDLE) && !rx_valid &&
                           (r_timer == TIMEOUT_CYCLES - 32'd1);

    // Idle-gap counter: cleared by every byte and whenever the loader is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'd0;
        end else if (rx_valid || (r_state == S_IDLE)) begin
            r_timer <= 32'd0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Frame parser, memory write port and status outputs (all registered)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= 16'd0;
            r_index       <= 17'd0;
            r_checksum    <= 8'd0;
            write_enable  <= 1'b0;
            write_data    <= 8'd0;
            write_address <= 32'd0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        // Anything but the magic byte is line noise here
                        if (rx_data == c_MAGIC) begin
                            r_state  <= S_LEN_LO;
                            cpu_hold <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    S_LEN_LO: begin
                        r_len[7:0] <= rx_data;
                        r_state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        r_len[15:8] <= rx_data;
                        r_index     <= 17'd0;
                        r_checksum  <= 8'd0;
                        if (w_len_too_big) begin
                            // Image cannot fit: reject before touching memory
                            load_error <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_IDLE;
                        end else if (w_len_rx == 16'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        write_enable  <= 1'b1;
                        write_data    <= rx_data;
                        write_address <= 32'(r_index);
                        r_index       <= r_index + 17'd1;
                        r_checksum    <= r_checksum + rx_data;
                        if (w_last_byte) begin
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        // Release the core only on a matching checksum
                        if (rx_data == r_checksum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                        end
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                // Stalled sender: abandon the frame, keep the core held
                load_error <= 1'b1;
                busy       <= 1'b0;
                r_state    <= S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Expected memory writes
//               are queued as frames are sent and matched by a write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int unsigned c_MEM_BYTES = 1024;
    localparam int unsigned c_TIMEOUT   = 16;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        write_enable;
    logic [7:0]  write_data;
    logic [31:0] write_address;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writes: {address, data}
    logic [39:0] exp_q[$];

    program_loader #(
        .MEM_BYTES      (c_MEM_BYTES),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .write_address (write_address),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every write must match the head of the expected queue
    always @(negedge clk) begin
        logic [39:0] exp_w;
        if (write_enable) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, none expected",
                         write_address, write_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({write_address, write_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL write_content: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             write_address, write_data, exp_w[39:8], exp_w[7:0]);
                end
            end
        end
        if (load_done || load_error) begin
            n_checks++;
            if (load_done && load_error) begin
                n_fail++;
                $display("FAIL done_error_exclusive: load_done=%b load_error=%b, expected not both",
                         load_done, load_error);
            end
        end
    end

    // One byte strobe; returns #1 after the sampling edge
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({write_enable, write_data, write_address, cpu_hold, busy, load_done, load_error} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b wd=%02h wa=%0d hold=%b busy=%b done=%b err=%b, expected all 0",
                     write_enable, write_data, write_address, cpu_hold, busy, load_done, load_error);
        end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_idle_ignore();
        logic [7:0] noise [3] = '{8'h00, 8'hFF, 8'h5A};
        foreach (noise[i]) begin
            send(noise[i]);
            n_checks++;
            if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ignore_%02h: got busy=%b hold=%b, expected 0/0", noise[i], busy, cpu_hold);
            end
        end
    endtask

    task automatic test_good_load();
        logic [7:0] pl [3] = '{8'h11, 8'h22, 8'h33};
        send(8'hA5);
        n_checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL magic_hold: got busy=%b hold=%b, expected 1/1", busy, cpu_hold);
        end
        send(8'h03);
        send(8'h00);
        foreach (pl[i]) begin
            exp_q.push_back({32'(i), pl[i]});
            send(pl[i]);
            n_checks++;
            if (write_enable !== 1'b1) begin
                n_fail++;
                $display("FAIL good_write_timing_%0d: got write_enable=%b, expected 1", i, write_enable);
            end
        end
        idle_cycle();
        n_checks++;
        if (write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL good_write_width: got write_enable=%b, expected 0", write_enable);
        end
        send(8'h66);
        n_checks++;
        if (load_done !== 1'b1 || load_error !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL good_done: got done=%b err=%b hold=%b, expected 1/0/0", load_done, load_error, cpu_hold);
        end
        idle_cycle();
        n_checks++;
        if (load_done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_after: got done=%b busy=%b pending=%0d, expected 0/0/0", load_done, busy, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        send(8'hA5); send(8'h02); send(8'h00);
        exp_q.push_back({32'd0, 8'h10});
        send(8'h10);
        exp_q.push_back({32'd1, 8'h20});
        send(8'h20);
        send(8'h31);
        n_checks++;
        if (load_error !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_chk_error: got err=%b done=%b hold=%b, expected 1/0/1", load_error, load_done, cpu_hold);
        end
        send(8'h00);
        n_checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b0 || load_error !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_chk_sticky: got hold=%b busy=%b err=%b pending=%0d, expected 1/0/0/0",
                     cpu_hold, busy, load_error, exp_q.size());
        end
    endtask

    task automatic test_len_too_big();
        send(8'hA5); send(8'h01); send(8'h04);
        n_checks++;
        if (load_error !== 1'b1 || busy !== 1'b0 || write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL len_too_big: got err=%b busy=%b we=%b, expected 1/0/0", load_error, busy, write_enable);
        end
        send(8'hA5); send(8'h00); send(8'h00);
        send(8'h00);
        n_checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: got done=%b hold=%b, expected 1/0", load_done, cpu_hold);
        end
    endtask

    // LEN == MEM_BYTES, back-to-back, last address MEM_BYTES-1
    task automatic test_full_size();
        logic [7:0] sum = 8'd0;
        logic [7:0] d;
        send(8'hA5); send(8'h00); send(8'h04);
        for (int i = 0; i < int'(c_MEM_BYTES); i++) begin
            d = 8'($urandom_range(0, 255));
            if (i == 0) d = 8'hA5;
            sum = sum + d;
            exp_q.push_back({32'(i), d});
            send(d);
        end
        send(sum);
        n_checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL full_size_done: got done=%b hold=%b, expected 1/0", load_done, cpu_hold);
        end
        idle_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_size_writes: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        send(8'hA5); send(8'h04); send(8'h00);
        exp_q.push_back({32'd0, 8'hAA});
        send(8'hAA);
        for (int k = 1; k <= int'(c_TIMEOUT); k++) begin
            idle_cycle();
            if (k == int'(c_TIMEOUT) - 1 || k == int'(c_TIMEOUT)) begin
                n_checks++;
                if (load_error !== (k == int'(c_TIMEOUT))) begin
                    n_fail++;
                    $display("FAIL timeout_edge_%0d: got err=%b, expected %b", k, load_error, k == int'(c_TIMEOUT));
                end
            end
        end
        idle_cycle();
        n_checks++;
        if (load_error !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_after: got err=%b busy=%b hold=%b pending=%0d, expected 0/0/1/0",
                     load_error, busy, cpu_hold, exp_q.size());
        end
    endtask

    task automatic test_back_to_back_reset();
        send(8'hA5); send(8'h04); send(8'h00);
        exp_q.push_back({32'd0, 8'h01});
        send(8'h01);
        exp_q.push_back({32'd1, 8'h02});
        send(8'h02);
        // Reset arrives together with the third payload byte
        reset    = 1'b1;
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_data = 8'h04;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reset    = 1'b0;
        n_checks++;
        if ({write_enable, write_data, write_address, cpu_hold, busy, load_done, load_error} !== 49'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got we=%b wd=%02h wa=%0d hold=%b busy=%b done=%b err=%b, expected all 0",
                     write_enable, write_data, write_address, cpu_hold, busy, load_done, load_error);
        end
        send(8'hA5); send(8'h02); send(8'h00);
        exp_q.push_back({32'd0, 8'h05});
        send(8'h05);
        exp_q.push_back({32'd1, 8'h06});
        send(8'h06);
        send(8'h0B);
        n_checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_load: got done=%b hold=%b, expected 1/0", load_done, cpu_hold);
        end
        idle_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_writes: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_good_load();
        test_bad_checksum();
        test_len_too_big();
        test_full_size();
        test_timeout();
        test_back_to_back_reset();
        repeat (2) idle_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
